mmio_dispatch: RTL and testbench

- Sequences PSL MMIO transactions onto one config-space responder (AFU descriptor) and NUM_CLIENTS problem-state register clients.
- Decodes the address, issues a single-cycle request, waits for the client ack with a timeout, then returns one registered ack/data/parity beat to the PSL.
- Sits between the PSL MMIO interface and all AFU register blocks.
- At most one transaction is ever in flight.

---
 rtl/mmio_dispatch_pkg.sv | 54 +++++
 rtl/mmio_dispatch_addr_decode.sv | 35 +++
 rtl/mmio_dispatch.sv | 214 +++++++++++++++++++++
 tb/tb_mmio_dispatch.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_dispatch_pkg.sv
// Shared types and constants for the PSL MMIO dispatcher: interface structs,
// FSM/target encodings, error-flag bit positions and the read-data formatter.
package mmio_dispatch_pkg;

  localparam int MMIO_ADDR_W = 24;
  localparam int MMIO_DATA_W = 64;

  localparam logic [MMIO_DATA_W-1:0] MMIO_ALL_ONES = '1;

  localparam int ERR_ADDR_PAR  = 0;
  localparam int ERR_WDATA_PAR = 1;
  localparam int ERR_TIMEOUT   = 2;
  localparam int ERR_OVERLAP   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } mmio_dispatch_state_t;

  typedef enum logic [1:0] {
    TGT_CFG_RD   = 2'd0,
    TGT_CFG_WR   = 2'd1,
    TGT_CLIENT   = 2'd2,
    TGT_UNMAPPED = 2'd3
  } mmio_target_t;

  // PSL numbers bits big-endian: bit 0 is the MSB.
  typedef struct packed {
    logic                     valid;
    logic                     cfg;
    logic                     read;
    logic                     doubleword;
    logic [0:MMIO_ADDR_W-1]   address;
    logic                     address_parity;
    logic [0:MMIO_DATA_W-1]   data;
    logic                     data_parity;
  } MMIOInterfaceInput;

  typedef struct packed {
    logic                     ack;
    logic [0:MMIO_DATA_W-1]   data;
    logic                     data_parity;
  } MMIOInterfaceOutput;

  // Word reads return the low 32-bit word replicated in both halves.
  function automatic logic [MMIO_DATA_W-1:0] mmio_format_read(
    input logic [MMIO_DATA_W-1:0] rd,
    input logic                   dw
  );
    return dw ? rd : {rd[31:0], rd[31:0]};
  endfunction

endpackage

// File: rtl/mmio_dispatch_addr_decode.sv
// Combinational address decode: classifies a PSL MMIO request as config
// read/write, a mapped problem-state client, or an unmapped hole.
module mmio_addr_decode
  import mmio_dispatch_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int REGION_BITS = 8
) (
  input  logic [MMIO_ADDR_W-1:0] address,
  input  logic                   cfg,
  input  logic                   read,
  output mmio_target_t           kind,
  output logic [NUM_CLIENTS-1:0] sel,
  output logic [REGION_BITS-1:0] local_addr
);

  logic [MMIO_ADDR_W-1:0] idx;

  assign idx        = address >> REGION_BITS;
  assign local_addr = address[REGION_BITS-1:0];

  always_comb begin
    kind = TGT_UNMAPPED;
    sel  = '0;
    if (cfg) begin
      kind = read ? TGT_CFG_RD : TGT_CFG_WR;
    end else if (idx < MMIO_ADDR_W'(NUM_CLIENTS)) begin
      kind = TGT_CLIENT;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        sel[i] = (idx == MMIO_ADDR_W'(i));
      end
    end
  end

endmodule

// File: rtl/mmio_dispatch.sv
// PSL MMIO dispatcher: one transaction in flight, decoded onto the config
// responder or a problem-state client, answered with one registered ack beat.
module mmio_dispatch
  import mmio_dispatch_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int REGION_BITS = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clock,
  input  logic                        rstn,
  input  MMIOInterfaceInput           mmio_in,
  output MMIOInterfaceOutput          mmio_out,
  output logic                        cfg_req_valid,
  output logic [MMIO_ADDR_W-1:0]      cfg_req_addr,
  input  logic                        cfg_ack,
  input  logic [MMIO_DATA_W-1:0]      cfg_rdata,
  output logic [NUM_CLIENTS-1:0]      client_req_valid,
  output logic                        client_req_read,
  output logic                        client_req_dw,
  output logic [REGION_BITS-1:0]      client_req_addr,
  output logic [MMIO_DATA_W-1:0]      client_req_wdata,
  input  logic [NUM_CLIENTS-1:0]      client_ack,
  input  logic [NUM_CLIENTS*64-1:0]   client_rdata,
  output logic                        busy,
  output logic [3:0]                  err_status,
  output logic [1:0]                  dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Handshake: mmio_in.valid is a one-cycle strobe taken only in IDLE; each
  // req_valid is a one-cycle pulse whose fields hold until the response, and
  // the selected ack is honoured only in WAIT (from the pulse cycle on).

  mmio_dispatch_state_t state_q, state_d;

  logic [MMIO_ADDR_W-1:0] addr_v;
  mmio_target_t           dec_kind;
  logic [NUM_CLIENTS-1:0] dec_sel;
  logic [REGION_BITS-1:0] dec_local;
  logic                   addr_par_ok;
  logic                   wdata_par_ok;

  logic                   read_q;
  logic                   dw_q;
  logic [MMIO_ADDR_W-1:0] addr_q;
  logic [REGION_BITS-1:0] local_q;
  logic [MMIO_DATA_W-1:0] wdata_q;
  logic [NUM_CLIENTS-1:0] sel_q;
  logic                   tgt_cfg_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ack_q;
  logic [MMIO_DATA_W-1:0] data_q;
  logic [3:0]             err_q;
  logic                   cfg_req_valid_q;
  logic [NUM_CLIENTS-1:0] client_req_valid_q;

  logic                   accept;
  logic                   launch_cfg;
  logic                   launch_client;
  logic                   resp_load;
  logic [MMIO_DATA_W-1:0] resp_data_d;
  logic [3:0]             err_set;
  logic                   sel_ack;
  logic [MMIO_DATA_W-1:0] client_rd_sel;
  logic [MMIO_DATA_W-1:0] rd_sel;

  assign addr_v       = mmio_in.address;
  assign addr_par_ok  = (mmio_in.address_parity == ~^mmio_in.address);
  assign wdata_par_ok = mmio_in.read || (mmio_in.data_parity == ~^mmio_in.data);

  mmio_addr_decode #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .REGION_BITS (REGION_BITS)
  ) u_decode (
    .address    (addr_v),
    .cfg        (mmio_in.cfg),
    .read       (mmio_in.read),
    .kind       (dec_kind),
    .sel        (dec_sel),
    .local_addr (dec_local)
  );

  always_comb begin
    client_rd_sel = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (sel_q[i]) client_rd_sel = client_rdata[i*64 +: 64];
    end
  end

  assign sel_ack = tgt_cfg_q ? cfg_ack : |(client_ack & sel_q);
  assign rd_sel  = tgt_cfg_q ? cfg_rdata : client_rd_sel;

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    launch_cfg    = 1'b0;
    launch_client = 1'b0;
    resp_load     = 1'b0;
    resp_data_d   = '0;
    err_set       = '0;
    case (state_q)
      IDLE: begin
        if (mmio_in.valid) begin
          accept = 1'b1;
          if (!addr_par_ok) begin
            err_set[ERR_ADDR_PAR] = 1'b1;
            resp_load             = 1'b1;
            resp_data_d           = MMIO_ALL_ONES;
            state_d               = RESPOND;
          end else if (!wdata_par_ok) begin
            err_set[ERR_WDATA_PAR] = 1'b1;
            resp_load              = 1'b1;
            resp_data_d            = MMIO_ALL_ONES;
            state_d                = RESPOND;
          end else begin
            case (dec_kind)
              TGT_CFG_RD: begin
                launch_cfg = 1'b1;
                state_d    = WAIT;
              end
              TGT_CLIENT: begin
                launch_client = 1'b1;
                state_d       = WAIT;
              end
              TGT_UNMAPPED: begin
                resp_load   = 1'b1;
                resp_data_d = mmio_in.read ? MMIO_ALL_ONES : '0;
                state_d     = RESPOND;
              end
              default: begin
                resp_load = 1'b1;
                state_d   = RESPOND;
              end
            endcase
          end
        end
      end
      WAIT: begin
        err_set[ERR_OVERLAP] = mmio_in.valid;
        // A late ack on the final counted cycle still beats the timeout.
        if (sel_ack) begin
          resp_load   = 1'b1;
          resp_data_d = read_q ? mmio_format_read(rd_sel, dw_q) : '0;
          state_d     = RESPOND;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          resp_load            = 1'b1;
          resp_data_d          = MMIO_ALL_ONES;
          state_d              = RESPOND;
        end
      end
      RESPOND: begin
        err_set[ERR_OVERLAP] = mmio_in.valid;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q            <= IDLE;
      read_q             <= 1'b0;
      dw_q               <= 1'b0;
      addr_q             <= '0;
      local_q            <= '0;
      wdata_q            <= '0;
      sel_q              <= '0;
      tgt_cfg_q          <= 1'b0;
      cnt_q              <= '0;
      ack_q              <= 1'b0;
      data_q             <= '0;
      err_q              <= '0;
      cfg_req_valid_q    <= 1'b0;
      client_req_valid_q <= '0;
    end else begin
      state_q            <= state_d;
      err_q              <= err_q | err_set;
      ack_q              <= resp_load;
      data_q             <= resp_data_d;
      cfg_req_valid_q    <= launch_cfg;
      client_req_valid_q <= launch_client ? dec_sel : '0;
      if (accept) begin
        read_q    <= mmio_in.read;
        dw_q      <= mmio_in.doubleword;
        addr_q    <= addr_v;
        local_q   <= dec_local;
        wdata_q   <= mmio_in.data;
        sel_q     <= dec_sel;
        tgt_cfg_q <= (dec_kind == TGT_CFG_RD);
      end
      if (state_q == WAIT && state_d == WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign mmio_out         = '{ack: ack_q, data: data_q, data_parity: ~^data_q};
  assign cfg_req_valid    = cfg_req_valid_q;
  assign cfg_req_addr     = addr_q;
  assign client_req_valid = client_req_valid_q;
  assign client_req_read  = read_q;
  assign client_req_dw    = dw_q;
  assign client_req_addr  = local_q;
  assign client_req_wdata = wdata_q;
  assign busy             = (state_q != IDLE);
  assign err_status       = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mmio_dispatch.sv
// Self-checking bench for mmio_dispatch: directed scenarios plus randomized
// back-to-back traffic scored against a transaction-level response model.
module tb_mmio_dispatch;
  import mmio_dispatch_pkg::*;

  localparam int NC = 4;
  localparam int RB = 8;
  localparam int TO = 255;

  logic                 clock = 1'b0;
  logic                 rstn  = 1'b0;
  MMIOInterfaceInput    mmio_in;
  MMIOInterfaceOutput   mmio_out;
  logic                 cfg_req_valid;
  logic [23:0]          cfg_req_addr;
  logic                 cfg_ack;
  logic [63:0]          cfg_rdata;
  logic [NC-1:0]        client_req_valid;
  logic                 client_req_read;
  logic                 client_req_dw;
  logic [RB-1:0]        client_req_addr;
  logic [63:0]          client_req_wdata;
  logic [NC-1:0]        client_ack;
  logic [NC*64-1:0]     client_rdata;
  logic                 busy;
  logic [3:0]           err_status;
  logic [1:0]           dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  exp_err  = '0;
  logic [63:0] exp_q[$];

  typedef struct {
    int          kind;   // 0 decode-terminated, 1 cfg read, 2 client
    int          idx;
    int          lat;
    logic [63:0] data;
    logic [3:0]  err;
  } exp_t;

  mmio_dispatch #(.NUM_CLIENTS(NC), .REGION_BITS(RB), .TIMEOUT(TO)) dut (
    .clock            (clock),
    .rstn             (rstn),
    .mmio_in          (mmio_in),
    .mmio_out         (mmio_out),
    .cfg_req_valid    (cfg_req_valid),
    .cfg_req_addr     (cfg_req_addr),
    .cfg_ack          (cfg_ack),
    .cfg_rdata        (cfg_rdata),
    .client_req_valid (client_req_valid),
    .client_req_read  (client_req_read),
    .client_req_dw    (client_req_dw),
    .client_req_addr  (client_req_addr),
    .client_req_wdata (client_req_wdata),
    .client_ack       (client_ack),
    .client_rdata     (client_rdata),
    .busy             (busy),
    .err_status       (err_status),
    .dbg_state        (dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  // Expected response from the transaction rules: latency in cycles after
  // the accepting edge, response data and error flags raised.
  function automatic exp_t model(input logic cfg, input logic rd, input logic dw,
                                 input logic [23:0] addr, input logic apar_bad,
                                 input logic dpar_bad, input int delay,
                                 input logic [63:0] rdata);
    exp_t e;
    int   region;
    e.kind = 0; e.idx = 0; e.lat = 1; e.data = '0; e.err = '0;
    region = int'(addr) / (1 << RB);
    if (apar_bad) begin
      e.err = 4'b0001; e.data = '1;
    end else if (!rd && dpar_bad) begin
      e.err = 4'b0010; e.data = '1;
    end else if (cfg && !rd) begin
      e.data = '0;
    end else if (!cfg && region >= NC) begin
      e.data = rd ? '1 : '0;
    end else begin
      e.kind = cfg ? 1 : 2;
      e.idx  = cfg ? 0 : region;
      if (delay < 0 || delay + 1 > TO + 1) begin
        e.lat = TO + 2; e.data = '1; e.err = 4'b0100;
      end else begin
        e.lat = delay + 2;
        if (!rd)     e.data = '0;
        else if (dw) e.data = rdata;
        else         e.data = {rdata[31:0], rdata[31:0]};
      end
    end
    return e;
  endfunction

  task automatic do_reset;
    rstn       = 1'b0;
    mmio_in    = '0;
    cfg_ack    = 1'b0;
    client_ack = '0;
    cfg_rdata  = '0;
    client_rdata = '0;
    repeat (3) @(negedge clock);
    rstn    = 1'b1;
    exp_err = '0;
    @(negedge clock);
  endtask

  // Issues one request at the current negedge, plays the responder with an
  // ack 'delay' cycles after the request pulse (negative = never), and checks
  // the pulse, the response beat and the idle cycle after it.
  task automatic run_txn(input string name, input logic cfg, input logic rd,
                         input logic dw, input logic [23:0] addr,
                         input logic [63:0] wdata, input logic apar_bad,
                         input logic dpar_bad, input int delay,
                         input logic [63:0] rdata, input int inject);
    exp_t        e;
    logic [NC-1:0] oh;
    logic [NC-1:0] noise;
    logic [63:0] exp_data;
    bit          got = 0;
    int          ack_cyc = 0;
    e  = model(cfg, rd, dw, addr, apar_bad, dpar_bad, delay, rdata);
    oh = (e.kind == 2) ? NC'(1) << e.idx : '0;
    exp_q.push_back(e.data);
    exp_err = exp_err | e.err | (inject > 0 ? 4'b1000 : 4'b0000);
    for (int i = 0; i < NC; i++) client_rdata[i*64 +: 64] = {$urandom, $urandom};
    if (e.kind == 2) client_rdata[e.idx*64 +: 64] = rdata;
    cfg_rdata = (e.kind == 1) ? rdata : {$urandom, $urandom};
    mmio_in.valid          = 1'b1;
    mmio_in.cfg            = cfg;
    mmio_in.read           = rd;
    mmio_in.doubleword     = dw;
    mmio_in.address        = addr;
    mmio_in.address_parity = apar_bad ? ^addr : ~^addr;
    mmio_in.data           = wdata;
    mmio_in.data_parity    = dpar_bad ? ^wdata : ~^wdata;
    @(posedge clock);
    #1;
    mmio_in = '0;
    for (int c = 1; c <= TO + 10 && !got; c++) begin
      @(negedge clock);
      mmio_in.valid = (c == inject);
      if (c == inject) begin
        mmio_in.address = 24'($urandom);
        mmio_in.read    = 1'($urandom);
        mmio_in.cfg     = 1'($urandom);
      end
      noise      = NC'($urandom) & ~oh;
      client_ack = noise | ((e.kind == 2 && c == delay + 1) ? oh : '0);
      cfg_ack    = (e.kind == 1) ? (c == delay + 1) : 1'($urandom);
      if (c == 1) begin
        n_checks++;
        if (e.kind == 1) begin
          if (cfg_req_valid !== 1'b1 || cfg_req_addr !== addr || client_req_valid !== '0) begin
            n_fail++;
            $display("FAIL %s cfg_pulse: cfg_req_valid=%b addr=%h client_req_valid=%b, need 1 %h 0",
                     name, cfg_req_valid, cfg_req_addr, client_req_valid, addr);
          end
        end else if (e.kind == 2) begin
          if (client_req_valid !== oh || cfg_req_valid !== 1'b0 ||
              client_req_addr !== addr[RB-1:0] || client_req_read !== rd ||
              client_req_dw !== dw || (!rd && client_req_wdata !== wdata)) begin
            n_fail++;
            $display("FAIL %s client_pulse: valid=%b addr=%h rd=%b dw=%b wdata=%h, need %b %h %b %b %h",
                     name, client_req_valid, client_req_addr, client_req_read, client_req_dw,
                     client_req_wdata, oh, addr[RB-1:0], rd, dw, wdata);
          end
        end else begin
          if (client_req_valid !== '0 || cfg_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s no_pulse: client_req_valid=%b cfg_req_valid=%b, need 0 0",
                     name, client_req_valid, cfg_req_valid);
          end
        end
      end
      if (c == 2) begin
        n_checks++;
        if (client_req_valid !== '0 || cfg_req_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s pulse_width: client_req_valid=%b cfg_req_valid=%b in cycle 2, need 0 0",
                   name, client_req_valid, cfg_req_valid);
        end
      end
      if (mmio_out.ack === 1'b1) begin
        got      = 1;
        ack_cyc  = c;
        exp_data = exp_q.pop_front();
        n_checks++;
        if (ack_cyc != e.lat) begin
          n_fail++;
          $display("FAIL %s latency: ack in cycle %0d, need cycle %0d", name, ack_cyc, e.lat);
        end
        n_checks++;
        if (mmio_out.data !== exp_data) begin
          n_fail++;
          $display("FAIL %s data: got %h, need %h", name, mmio_out.data, exp_data);
        end
        n_checks++;
        if (mmio_out.data_parity !== ~^exp_data) begin
          n_fail++;
          $display("FAIL %s parity: got %b, need %b", name, mmio_out.data_parity, ~^exp_data);
        end
        n_checks++;
        if (err_status !== exp_err) begin
          n_fail++;
          $display("FAIL %s err_status: got %b, need %b", name, err_status, exp_err);
        end
        if (e.kind == 2) begin
          n_checks++;
          if (client_req_addr !== addr[RB-1:0] || client_req_read !== rd) begin
            n_fail++;
            $display("FAIL %s field_hold: addr=%h rd=%b at response, need %h %b",
                     name, client_req_addr, client_req_read, addr[RB-1:0], rd);
          end
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      void'(exp_q.pop_front());
      $display("FAIL %s ack_timeout: no ack within %0d cycles, need ack in cycle %0d",
               name, TO + 10, e.lat);
    end else begin
      @(negedge clock);
      client_ack = '0;
      cfg_ack    = 1'b0;
      mmio_in    = '0;
      n_checks++;
      if (mmio_out.ack !== 1'b0 || mmio_out.data !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s post_ack: ack=%b data=%h busy=%b, need 0 0 0",
                 name, mmio_out.ack, mmio_out.data, busy);
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if (mmio_out.ack !== 1'b0 || mmio_out.data !== '0 || busy !== 1'b0 ||
        err_status !== 4'b0 || client_req_valid !== '0 || cfg_req_valid !== 1'b0 ||
        dbg_state !== 2'(IDLE)) begin
      n_fail++;
      $display("FAIL reset_values: ack=%b data=%h busy=%b err=%b creq=%b cfgreq=%b state=%0d, need all 0",
               mmio_out.ack, mmio_out.data, busy, err_status, client_req_valid,
               cfg_req_valid, dbg_state);
    end
  endtask

  task automatic test_cfg_read;
    run_txn("cfg_read", 1, 1, 1, 24'h000000, 64'h0, 0, 0, 2, 64'h0000_0001_0000_8010, 0);
  endtask

  task automatic test_client_write;
    run_txn("client_write", 0, 0, 1, 24'h000105, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 64'h0, 0);
  endtask

  task automatic test_word_read;
    run_txn("word_read", 0, 1, 0, 24'h000237, 64'h0, 0, 0, 1, 64'h11112222_33334444, 0);
  endtask

  task automatic test_decode_terminated;
    run_txn("unmapped_read", 0, 1, 1, 24'h000400, 64'h0, 0, 0, 0, 64'h0, 0);
    run_txn("unmapped_write", 0, 0, 1, 24'h012345, 64'h1234, 0, 0, 0, 64'h0, 0);
    run_txn("cfg_write", 1, 0, 1, 24'h000010, 64'h55AA, 0, 0, 0, 64'h0, 0);
    run_txn("addr_parity", 0, 1, 1, 24'h000105, 64'h0, 1, 0, 0, 64'h0, 0);
    run_txn("wdata_parity", 0, 0, 1, 24'h000302, 64'hF0F0_0F0F_1234_5678, 0, 1, 0, 64'h0, 0);
  endtask

  task automatic test_timeout;
    do_reset();
    run_txn("timeout", 0, 1, 1, 24'h000020, 64'h0, 0, 0, -1, 64'hABCD, 0);
    do_reset();
    run_txn("timeout_ack_wins", 0, 1, 1, 24'h000021, 64'h0, 0, 0, TO, 64'h0123_4567_89AB_CDEF, 0);
    run_txn("timeout_ack_late", 0, 1, 1, 24'h000022, 64'h0, 0, 0, TO + 1, 64'h0123_4567_89AB_CDEF, 0);
  endtask

  task automatic test_overlap;
    do_reset();
    run_txn("overlap", 0, 1, 1, 24'h000310, 64'h0, 0, 0, 5, 64'hCAFE_0000_BEEF_1111, 2);
  endtask

  task automatic test_reset_mid;
    bit saw_ack = 0;
    mmio_in = '0;
    mmio_in.valid          = 1'b1;
    mmio_in.read           = 1'b1;
    mmio_in.doubleword     = 1'b1;
    mmio_in.address        = 24'h000010;
    mmio_in.address_parity = ~^24'h000010;
    @(posedge clock);
    #1;
    mmio_in = '0;
    repeat (3) begin
      @(negedge clock);
      saw_ack |= mmio_out.ack;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy: busy=%b before reset, need 1", busy);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mmio_out.ack !== 1'b0 || err_status !== 4'b0 ||
        client_req_valid !== '0 || client_req_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: busy=%b ack=%b err=%b creq=%b caddr=%h, need all 0",
               busy, mmio_out.ack, err_status, client_req_valid, client_req_addr);
    end
    repeat (3) begin
      @(negedge clock);
      saw_ack |= mmio_out.ack;
    end
    rstn    = 1'b1;
    exp_err = '0;
    repeat (5) begin
      @(negedge clock);
      saw_ack |= mmio_out.ack;
    end
    n_checks++;
    if (saw_ack || dbg_state !== 2'(IDLE) || mmio_out.data !== '0 ||
        cfg_req_addr !== '0 || client_req_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_after: saw_ack=%0d state=%0d data=%h cfgaddr=%h wdata=%h, need 0 IDLE 0 0 0",
               saw_ack, dbg_state, mmio_out.data, cfg_req_addr, client_req_wdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] addr;
    logic        cfg, rd, dw, apb, dpb;
    int          sel;
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 9);
      cfg  = 1'b0;
      rd   = 1'($urandom);
      dw   = 1'($urandom);
      apb  = 1'b0;
      dpb  = 1'b0;
      addr = {8'h00, 4'h0, 2'b00, 2'($urandom_range(0, NC - 1)), 8'($urandom)};
      case (sel)
        0: apb = 1'b1;
        1: begin rd = 1'b0; dpb = 1'b1; end
        2: begin cfg = 1'b1; rd = 1'b0; addr = 24'($urandom); end
        3: begin cfg = 1'b1; rd = 1'b1; addr = 24'($urandom); end
        4: addr = {16'($urandom_range(NC, 16'hFFFF)), 8'($urandom)};
        default: ;
      endcase
      run_txn("random", cfg, rd, dw, addr, {$urandom, $urandom}, apb, dpb,
              $urandom_range(0, 6), {$urandom, $urandom}, 0);
    end
  endtask

  initial begin
    mmio_in      = '0;
    cfg_ack      = 1'b0;
    client_ack   = '0;
    cfg_rdata    = '0;
    client_rdata = '0;
    test_reset();
    test_cfg_read();
    test_client_write();
    test_word_read();
    test_decode_terminated();
    test_timeout();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
